// File: rtl/toy_fetch_queue_pkg.sv
// -----------------------------------------------------------------------------
// toy_pack
// Shared types and sizing for the fetch queue: the per-lane instruction
// payload, the number of filter lanes delivered per enqueue, the default
// queue depth and its pointer width (index bits plus one wrap bit).
// Ports: none (package).
// -----------------------------------------------------------------------------
package toy_pack;

    localparam int FILTER_CHANNEL = 4;
    localparam int FQ_DEPTH       = 16;
    localparam int FQ_PTR_WIDTH   = $clog2(FQ_DEPTH) + 1;

    // Wide enough to hold a lane count 0..FILTER_CHANNEL.
    localparam int LANE_CNT_W     = $clog2(FILTER_CHANNEL) + 1;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_queue_pkg;

endpackage

// File: rtl/toy_fetch_queue_if.sv
// -----------------------------------------------------------------------------
// toy_fetch_queue_if
// Bundles the enqueue side (BPU filter -> queue) and the dequeue side
// (queue -> decode) of the fetch queue.
//   fetch_queue_rdy  queue -> filter, room for a full lane group
//   fetch_queue_vld  filter -> queue, enqueue valid
//   fetch_queue_pld  filter -> queue, per-lane payload
//   fetch_queue_en   filter -> queue, per-lane enable
//   dec_vld          queue -> decode, per-slot valid
//   dec_pld          queue -> decode, head entries, oldest in slot 0
//   dec_rdy          decode -> queue, all valid slots consumed
// Modports: master = filter/decode environment, slave = the queue.
// -----------------------------------------------------------------------------
interface toy_fetch_queue_if #(
    parameter int FQ_DEQ_WIDTH = 1
) ();
    import toy_pack::*;

    logic                                      fetch_queue_rdy;
    logic                                      fetch_queue_vld;
    fetch_queue_pkg [FILTER_CHANNEL-1:0]       fetch_queue_pld;
    logic           [FILTER_CHANNEL-1:0]       fetch_queue_en;
    logic           [FQ_DEQ_WIDTH-1:0]         dec_vld;
    fetch_queue_pkg [FQ_DEQ_WIDTH-1:0]         dec_pld;
    logic                                      dec_rdy;

    modport master (
        input  fetch_queue_rdy,
        output fetch_queue_vld,
        output fetch_queue_pld,
        output fetch_queue_en,
        input  dec_vld,
        input  dec_pld,
        output dec_rdy
    );

    modport slave (
        output fetch_queue_rdy,
        input  fetch_queue_vld,
        input  fetch_queue_pld,
        input  fetch_queue_en,
        output dec_vld,
        output dec_pld,
        input  dec_rdy
    );

endinterface

// File: rtl/toy_fq_compact.sv
// -----------------------------------------------------------------------------
// toy_fq_compact
// Turns a lane enable mask into a per-lane write offset (number of enabled
// lanes below it) and the total number of enabled lanes.
//   en_i      lane enable mask
//   offset_o  per-lane slot offset within the compacted group
//   popcnt_o  number of enabled lanes
// -----------------------------------------------------------------------------
module toy_fq_compact
    import toy_pack::*;
(
    input  logic [FILTER_CHANNEL-1:0]                  en_i,
    output logic [FILTER_CHANNEL-1:0][LANE_CNT_W-1:0]  offset_o,
    output logic [LANE_CNT_W-1:0]                      popcnt_o
);

    // Running prefix count: a lane's offset is the count before it is added.
    always_comb begin : p_scan
        logic [LANE_CNT_W-1:0] acc;
        acc = '0;
        for (int i = 0; i < FILTER_CHANNEL; i++) begin
            offset_o[i] = acc;
            acc         = acc + LANE_CNT_W'(en_i[i]);
        end
        popcnt_o = acc;
    end

endmodule

// File: rtl/toy_fetch_queue.sv
// -----------------------------------------------------------------------------
// toy_fetch_queue
// Circular instruction queue between the BPU filter and decode. Enabled
// lanes of a group are compacted into consecutive entries; decode sees up to
// FQ_DEQ_WIDTH head entries per cycle. A backend redirect empties the queue.
//   clk                single clock
//   rst_n              asynchronous active-low reset
//   bus                toy_fetch_queue_if.slave (enqueue + decode handshakes)
//   fe_ctrl_be_chgflw  backend redirect, flushes the queue
//   fq_count           current occupancy
// Optional feature macro TOY_FQ_BYPASS_EN: when the queue is empty, incoming
// compacted lanes are presented to decode in the same cycle and lanes that
// decode takes are not stored.
// -----------------------------------------------------------------------------
module toy_fetch_queue #(
    parameter int FQ_DEPTH     = toy_pack::FQ_DEPTH,
    parameter int FQ_DEQ_WIDTH = 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    toy_fetch_queue_if.slave           bus,
    input  logic                       fe_ctrl_be_chgflw,
    output logic [$clog2(FQ_DEPTH):0]  fq_count
);

    localparam int FC    = toy_pack::FILTER_CHANNEL;
    localparam int CNT_W = toy_pack::LANE_CNT_W;
    localparam int IDX_W = $clog2(FQ_DEPTH);
    localparam int PTR_W = IDX_W + 1;

    logic [PTR_W-1:0]                wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]                rd_ptr_q, rd_ptr_d;
    toy_pack::fetch_queue_pkg        mem_q [FQ_DEPTH];

    logic [PTR_W-1:0]                count;
    logic [FC-1:0][CNT_W-1:0]        lane_off;
    logic [CNT_W-1:0]                enq_cnt;
    logic                            enq_fire;
    logic [FC-1:0][IDX_W-1:0]        lane_idx;
    logic [FC-1:0]                   lane_wr;
    logic [FC-1:0]                   lane_skip;
    logic [FQ_DEQ_WIDTH-1:0]         stored_vld;
    toy_pack::fetch_queue_pkg [FQ_DEQ_WIDTH-1:0] stored_pld;
    logic [FQ_DEQ_WIDTH-1:0]         dec_vld;
    logic [PTR_W-1:0]                deq_cnt;

    // Wrap bit makes the plain difference the true occupancy, including full.
    assign count    = wr_ptr_q - rd_ptr_q;
    assign fq_count = count;

    // Ready only from pointer state: room for a whole lane group.
    assign bus.fetch_queue_rdy = (PTR_W'(FQ_DEPTH) - count) >= PTR_W'(FC);
    assign enq_fire = bus.fetch_queue_vld & bus.fetch_queue_rdy & ~fe_ctrl_be_chgflw;

    toy_fq_compact u_compact (
        .en_i     (bus.fetch_queue_en),
        .offset_o (lane_off),
        .popcnt_o (enq_cnt)
    );

    for (genvar gi = 0; gi < FC; gi++) begin : g_lane
        assign lane_idx[gi] = wr_ptr_q[IDX_W-1:0] + IDX_W'(lane_off[gi]);
        assign lane_wr[gi]  = enq_fire & bus.fetch_queue_en[gi] & ~lane_skip[gi];
    end

    // Head entries straight from storage; index arithmetic wraps naturally.
    always_comb begin
        for (int s = 0; s < FQ_DEQ_WIDTH; s++) begin
            stored_vld[s] = count > PTR_W'(s);
            stored_pld[s] = mem_q[rd_ptr_q[IDX_W-1:0] + IDX_W'(s)];
        end
    end

`ifdef TOY_FQ_BYPASS_EN
    logic                                        byp_active;
    logic [FQ_DEQ_WIDTH-1:0]                     byp_vld;
    toy_pack::fetch_queue_pkg [FQ_DEQ_WIDTH-1:0] byp_pld;

    assign byp_active = (count == '0);

    // Decode slot s takes the enabled lane whose compacted offset is s.
    always_comb begin
        byp_vld = '0;
        byp_pld = '0;
        for (int s = 0; s < FQ_DEQ_WIDTH; s++) begin
            for (int l = 0; l < FC; l++) begin
                if (enq_fire && bus.fetch_queue_en[l] && lane_off[l] == CNT_W'(s)) begin
                    byp_vld[s] = 1'b1;
                    byp_pld[s] = bus.fetch_queue_pld[l];
                end
            end
        end
    end

    assign dec_vld     = byp_active ? byp_vld : stored_vld;
    assign bus.dec_pld = byp_active ? byp_pld : stored_pld;

    // Consumed bypass lanes still advance both pointers, so their slots are
    // skipped by the read pointer and never need to be written.
    for (genvar gi = 0; gi < FC; gi++) begin : g_skip
        assign lane_skip[gi] = byp_active & bus.dec_rdy &
                               (lane_off[gi] < CNT_W'(FQ_DEQ_WIDTH));
    end
`else
    assign dec_vld     = stored_vld;
    assign bus.dec_pld = stored_pld;
    assign lane_skip   = '0;
`endif

    assign bus.dec_vld = dec_vld;

    always_comb begin
        deq_cnt = '0;
        for (int s = 0; s < FQ_DEQ_WIDTH; s++) begin
            deq_cnt = deq_cnt + PTR_W'(dec_vld[s]);
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (fe_ctrl_be_chgflw) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (enq_fire) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(enq_cnt);
            end
            if (bus.dec_rdy) begin
                rd_ptr_d = rd_ptr_q + deq_cnt;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Entry storage carries no reset; validity comes from the pointers.
    always_ff @(posedge clk) begin
        for (int l = 0; l < FC; l++) begin
            if (lane_wr[l]) begin
                mem_q[lane_idx[l]] <= bus.fetch_queue_pld[l];
            end
        end
    end

endmodule

// File: tb/tb_toy_fetch_queue.sv
// -----------------------------------------------------------------------------
// tb_toy_fetch_queue
// Directed bench for toy_fetch_queue (default build, FQ_DEPTH=16,
// FQ_DEQ_WIDTH=1, four filter lanes). A queue-based reference model is
// compared against the DUT on every falling clock edge; literal expectations
// after each directed step pin the model.
// -----------------------------------------------------------------------------
module tb_toy_fetch_queue;
    import toy_pack::*;

    localparam int DEPTH = 16;
    localparam int DEQ_W = 1;
    localparam int FC    = FILTER_CHANNEL;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       chg = 1'b0;
    logic [4:0] fq_count;

    int checks   = 0;
    int failures = 0;

    fetch_queue_pkg model_q[$];
    int m_occ;
    int m_deq;

    toy_fetch_queue_if #(.FQ_DEQ_WIDTH(DEQ_W)) bus ();

    toy_fetch_queue #(
        .FQ_DEPTH     (DEPTH),
        .FQ_DEQ_WIDTH (DEQ_W)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .bus               (bus),
        .fe_ctrl_be_chgflw (chg),
        .fq_count          (fq_count)
    );

    always #5 clk = ~clk;

    function automatic fetch_queue_pkg mk(input int tag, input int lane);
        fetch_queue_pkg p;
        p.pc   = 32'(32'h1000 * tag + 4 * lane);
        p.inst = 32'((tag << 8) | lane) ^ 32'hA5A5_0000;
        return p;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Reference model: a plain FIFO of payloads.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            model_q.delete();
        end else if (chg) begin
            model_q.delete();
        end else begin
            m_occ = model_q.size();
            if (bus.dec_rdy) begin
                m_deq = (m_occ < DEQ_W) ? m_occ : DEQ_W;
                repeat (m_deq) void'(model_q.pop_front());
            end
            if (bus.fetch_queue_vld && (DEPTH - m_occ >= FC)) begin
                for (int l = 0; l < FC; l++) begin
                    if (bus.fetch_queue_en[l]) model_q.push_back(bus.fetch_queue_pld[l]);
                end
            end
        end
    end

    // Continuous compare of every output against the model.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("cmp_count", 64'(fq_count), 64'(model_q.size()));
            chk("cmp_rdy", 64'(bus.fetch_queue_rdy), 64'((DEPTH - model_q.size()) >= FC));
            for (int s = 0; s < DEQ_W; s++) begin
                chk("cmp_vld", 64'(bus.dec_vld[s]), 64'(model_q.size() > s));
                if (model_q.size() > s) chk("cmp_pld", bus.dec_pld[s], model_q[s]);
            end
        end
    end

    task automatic step(input logic v, input logic [FC-1:0] e, input int tag,
                        input logic r, input logic c);
        bus.fetch_queue_vld = v;
        bus.fetch_queue_en  = e;
        for (int l = 0; l < FC; l++) bus.fetch_queue_pld[l] = mk(tag, l);
        bus.dec_rdy = r;
        chg         = c;
        @(posedge clk);
        #1;
        bus.fetch_queue_vld = 1'b0;
        bus.fetch_queue_en  = '0;
        bus.dec_rdy         = 1'b0;
        chg                 = 1'b0;
        $display("txn t=%0t vld=%b en=%b tag=%0d dec_rdy=%b chgflw=%b -> fq_count=%0d",
                 $time, v, e, tag, r, c, fq_count);
    endtask

    initial begin
        bus.fetch_queue_vld = 1'b0;
        bus.fetch_queue_en  = '0;
        bus.fetch_queue_pld = '0;
        bus.dec_rdy         = 1'b0;
        rst_n               = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_count", 64'(fq_count), 64'd0);
        chk("rst_rdy", 64'(bus.fetch_queue_rdy), 64'd1);
        chk("rst_vld", 64'(bus.dec_vld), 64'd0);
        rst_n = 1'b1;

        // Full group, then all-zero mask.
        step(1'b1, 4'b1111, 1, 1'b0, 1'b0);
        chk("enq4_count", 64'(fq_count), 64'd4);
        chk("enq4_head", bus.dec_pld[0], mk(1, 0));
        step(1'b1, 4'b0000, 99, 1'b0, 1'b0);
        chk("enq0_count", 64'(fq_count), 64'd4);

        // Sparse mask: lanes 1 and 3 land consecutively.
        step(1'b1, 4'b1010, 2, 1'b0, 1'b0);
        chk("sparse_count", 64'(fq_count), 64'd6);
        repeat (4) step(1'b0, 4'b0000, 0, 1'b1, 1'b0);
        chk("sparse_cnt2", 64'(fq_count), 64'd2);
        chk("sparse_lane1", bus.dec_pld[0], mk(2, 1));
        step(1'b0, 4'b0000, 0, 1'b1, 1'b0);
        chk("sparse_lane3", bus.dec_pld[0], mk(2, 3));
        step(1'b0, 4'b0000, 0, 1'b1, 1'b0);
        chk("drain_count", 64'(fq_count), 64'd0);
        chk("drain_vld", 64'(bus.dec_vld), 64'd0);

        // Fill to 13 of 16: not ready, write ignored.
        for (int t = 3; t <= 5; t++) step(1'b1, 4'b1111, t, 1'b0, 1'b0);
        step(1'b1, 4'b0001, 6, 1'b0, 1'b0);
        chk("fill_count", 64'(fq_count), 64'd13);
        chk("fill_rdy", 64'(bus.fetch_queue_rdy), 64'd0);
        step(1'b1, 4'b1111, 7, 1'b0, 1'b0);
        chk("ovf_count", 64'(fq_count), 64'd13);

        // Drain to 5, then enqueue 4 and dequeue 1 together.
        repeat (8) step(1'b0, 4'b0000, 0, 1'b1, 1'b0);
        chk("at5_count", 64'(fq_count), 64'd5);
        chk("at5_head", bus.dec_pld[0], mk(5, 0));
        step(1'b1, 4'b1111, 9, 1'b1, 1'b0);
        chk("simul_count", 64'(fq_count), 64'd8);

        // Redirect with enqueue and dequeue at count 8.
        step(1'b1, 4'b1111, 10, 1'b1, 1'b1);
        chk("flush_count", 64'(fq_count), 64'd0);
        chk("flush_vld", 64'(bus.dec_vld), 64'd0);
        step(1'b0, 4'b0000, 0, 1'b0, 1'b0);
        chk("flush_hold", 64'(fq_count), 64'd0);

        // Bring write index to 14, then write across the wrap.
        for (int t = 11; t <= 13; t++) step(1'b1, 4'b1111, t, 1'b0, 1'b0);
        step(1'b1, 4'b0011, 14, 1'b0, 1'b0);
        chk("pre_wrap_count", 64'(fq_count), 64'd14);
        repeat (12) step(1'b0, 4'b0000, 0, 1'b1, 1'b0);
        chk("pre_wrap_head", bus.dec_pld[0], mk(14, 0));
        step(1'b1, 4'b1111, 15, 1'b0, 1'b0);
        chk("wrap_count", 64'(fq_count), 64'd6);
        repeat (2) step(1'b0, 4'b0000, 0, 1'b1, 1'b0);
        for (int l = 0; l < FC; l++) begin
            chk("wrap_order", bus.dec_pld[0], mk(15, l));
            step(1'b0, 4'b0000, 0, 1'b1, 1'b0);
        end
        chk("wrap_drain", 64'(fq_count), 64'd0);

        // Asynchronous reset in the middle of a cycle.
        step(1'b1, 4'b1111, 16, 1'b0, 1'b0);
        chk("pre_arst", 64'(fq_count), 64'd4);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_count", 64'(fq_count), 64'd0);
        chk("arst_vld", 64'(bus.dec_vld), 64'd0);
        chk("arst_rdy", 64'(bus.fetch_queue_rdy), 64'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(1'b1, 4'b0110, 17, 1'b0, 1'b0);
        chk("post_arst_count", 64'(fq_count), 64'd2);
        chk("post_arst_head", bus.dec_pld[0], mk(17, 1));

        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/toy_fetch_queue.md
TOY_FETCH_QUEUE -- requirements
Module: toy_fetch_queue

Interface
REQ-001 SHALL have parameter FQ_DEPTH, default 16, entry count (power of two, >= 2*FILTER_CHANNEL).
REQ-002 SHALL have parameter FQ_DEQ_WIDTH, default 1, entries presented to decode per cycle (1..FILTER_CHANNEL).
REQ-003 SHALL have port clk  input  1  the block's single clock.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port fetch_queue_rdy  output  1  enqueue ready to the BPU filter.
REQ-006 SHALL have port fetch_queue_vld  input  1  enqueue valid.
REQ-007 SHALL have port fetch_queue_pld  input  fetch_queue_pkg[FILTER_CHANNEL]  per-lane instruction payload.
REQ-008 SHALL have port fetch_queue_en  input  FILTER_CHANNEL  per-lane write enable.
REQ-009 SHALL have port fe_ctrl_be_chgflw  input  1  backend redirect; flushes the queue.
REQ-010 SHALL have port dec_vld  output  FQ_DEQ_WIDTH  per-slot valid to decode.
REQ-011 SHALL have port dec_pld  output  fetch_queue_pkg[FQ_DEQ_WIDTH]  head entries, oldest in slot 0.
REQ-012 SHALL have port dec_rdy  input  1  decode accepts all asserted dec_vld slots this cycle.
REQ-013 SHALL have port fq_count  output  log2(FQ_DEPTH)+1  current occupancy.

Function
REQ-014 SHALL be a circular buffer with wr_ptr/rd_ptr of log2(FQ_DEPTH)+1 bits, the MSB being the wrap bit; full = equal index with different wrap bit, empty = identical pointers.
REQ-015 SHALL drive fetch_queue_rdy = (FQ_DEPTH - fq_count >= FILTER_CHANNEL), registered-state only, with no combinational path from fetch_queue_vld or dec_rdy.
REQ-016 SHALL, on fetch_queue_vld && fetch_queue_rdy && !fe_ctrl_be_chgflw, write the enabled lanes compacted in ascending lane order to consecutive entries from wr_ptr and advance wr_ptr by popcount(fetch_queue_en).
REQ-017 SHALL accept any en mask, including non-contiguous masks and all-zero; an all-zero mask leaves state unchanged.
REQ-018 SHALL assert dec_vld[i] iff fq_count > i; dec_pld[i] = entry at rd_ptr+i (modulo FQ_DEPTH).
REQ-019 SHALL, on dec_rdy, advance rd_ptr by popcount(dec_vld).
REQ-020 SHALL, on simultaneous enqueue and dequeue, update fq_count = fq_count + enq_n - deq_n in one cycle; an entry written in cycle N is first visible on dec_pld in cycle N+1.
REQ-021 SHALL, on fe_ctrl_be_chgflw, drop that cycle's enqueue and dequeue and reset both pointers and fq_count to 0 at the next edge; dec_vld is 0 the following cycle.
REQ-022 SHALL wrap both pointers correctly when a compacted write or multi-slot read crosses entry FQ_DEPTH-1.
REQ-023 SHALL never overflow; an enqueue with fetch_queue_rdy low is ignored.

Reset
REQ-024 SHALL, while rst_n is low, hold wr_ptr = rd_ptr = 0, fq_count = 0, dec_vld = 0 and fetch_queue_rdy = 1 after the edge; entry storage is not reset.
REQ-025 SHALL, when reset asserts mid-operation, discard all contents immediately and asynchronously.

Configuration
REQ-026 SHALL, with TOY_FQ_BYPASS_EN defined, present the compacted incoming lanes directly on dec_vld/dec_pld in the same cycle when the queue is empty, and skip storing those lanes that dec_rdy consumes.
REQ-027 SHALL, without TOY_FQ_BYPASS_EN, expose entries only from storage, giving a minimum latency of 1 cycle.

Structure
REQ-028 SHALL take fetch_queue_pkg, FILTER_CHANNEL, FQ_DEPTH and FQ_PTR_WIDTH from toy_pack.
REQ-029 SHALL put lane compaction (mask to per-lane offset and popcount) in the sub-module toy_fq_compact.

Verification
REQ-030 SHALL cover: reset, then en=4'b1111 with FILTER_CHANNEL=4 -> fq_count=4 next cycle, dec_pld[0]=lane0.
REQ-031 SHALL cover: en=4'b1010 -> lane1 then lane3 occupy consecutive entries, count +2.
REQ-032 SHALL cover: fill to 13 of 16 -> fetch_queue_rdy=0, and the write is ignored.
REQ-033 SHALL cover: wr_ptr index 14 with en=4'b1111 -> entries 14,15,0,1 written, wrap bit toggles, and readout order is preserved.
REQ-034 SHALL cover: fe_ctrl_be_chgflw together with vld and dec_rdy at count 8 -> count=0 next cycle, nothing written.
REQ-035 SHALL cover: enqueue 4 and dequeue 1 in the same cycle at count 5 -> count=8.
